// File: rtl/ccff_chain_loader.sv
// Bitstream loader for a configuration flip-flop (CCFF) chain.
// Takes WORD_W-bit words, MSB first, and drives the chain head one bit
// per prog_clk while chain_shift_en is high. The final word is truncated
// to the bits that still fit in the chain. A word whose bs_last flag is in
// the wrong place is a framing error.
//
// state | meaning
// ------+----------------------------------------------------------
// IDLE  | waiting for start; chain untouched
// LOAD  | accepting words and shifting bits into the chain
// DONE  | all CHAIN_LEN bits shifted; cfg_done held until start/reset
// ERR   | bs_last framing error; error held until start/reset
module ccff_chain_loader #(
    parameter int CHAIN_LEN = 66,
    parameter int WORD_W    = 8
) (
    input  logic              prog_clk,
    input  logic              prog_reset,
    input  logic              start,
    input  logic              abort,
    input  logic [WORD_W-1:0] bs_data,
    input  logic              bs_valid,
    input  logic              bs_last,
    output logic              bs_ready,
    output logic              ccff_head,
    output logic              chain_shift_en,
    output logic              cfg_done,
    output logic              busy,
    output logic              error
);

    localparam int NWORDS    = (CHAIN_LEN + WORD_W - 1) / WORD_W;
    localparam int LAST_BITS = CHAIN_LEN - (NWORDS - 1) * WORD_W;
    localparam int BC_W      = $clog2(CHAIN_LEN + 1);
    localparam int WC_W      = $clog2(NWORDS + 1);
    localparam int RC_W      = $clog2(WORD_W + 1);

    localparam logic [BC_W-1:0] BIT_TOTAL  = BC_W'(CHAIN_LEN);
    localparam logic [WC_W-1:0] WORD_TOTAL = WC_W'(NWORDS);
    localparam logic [WC_W-1:0] WORD_FINAL = WC_W'(NWORDS - 1);
    // Bits still left in the shift register after the MSB leaves on the accepting edge.
    localparam logic [RC_W-1:0] FULL_REM   = RC_W'(WORD_W - 1);
    localparam logic [RC_W-1:0] LAST_REM   = RC_W'(LAST_BITS - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_DONE,
        ST_ERR
    } state_t;

    state_t            state_q,     state_d;
    logic [WORD_W-1:0] shreg_q,     shreg_d;
    logic [RC_W-1:0]   rem_q,       rem_d;
    logic [WC_W-1:0]   word_cnt_q,  word_cnt_d;
    logic [BC_W-1:0]   bit_cnt_q,   bit_cnt_d;
    logic              ccff_head_q, ccff_head_d;
    logic              shift_en_q,  shift_en_d;
    logic              cfg_done_q,  cfg_done_d;
    logic              error_q,     error_d;

    logic accept;
    logic is_final;
    logic frame_err;

    // A new word is taken only once the shift register is empty, so its MSB can
    // go straight to ccff_head on the accepting edge and words stream without gaps.
    always_comb begin
        bs_ready  = (state_q == ST_LOAD) && (word_cnt_q < WORD_TOTAL) && (rem_q == '0);
        accept    = bs_valid && bs_ready;
        is_final  = (word_cnt_q == WORD_FINAL);
        frame_err = accept && (bs_last != is_final);
    end

    // Next-state, shift datapath and registered-output computation.
    always_comb begin
        state_d     = state_q;
        shreg_d     = shreg_q;
        rem_d       = rem_q;
        word_cnt_d  = word_cnt_q;
        bit_cnt_d   = bit_cnt_q;
        ccff_head_d = ccff_head_q;
        shift_en_d  = 1'b0;
        cfg_done_d  = cfg_done_q;
        error_d     = error_q;

        unique case (state_q)
            ST_LOAD: begin
                if (abort) begin
                    state_d = ST_IDLE;
                end else if (bit_cnt_q == BIT_TOTAL) begin
                    state_d    = ST_DONE;
                    cfg_done_d = 1'b1;
                end else if (frame_err) begin
                    // Offending word is dropped whole; nothing of it reaches the chain.
                    state_d = ST_ERR;
                    error_d = 1'b1;
                end else if (accept) begin
                    ccff_head_d = bs_data[WORD_W-1];
                    shift_en_d  = 1'b1;
                    shreg_d     = bs_data << 1;
                    rem_d       = is_final ? LAST_REM : FULL_REM;
                    word_cnt_d  = word_cnt_q + WC_W'(1);
                    bit_cnt_d   = bit_cnt_q + BC_W'(1);
                end else if (rem_q != '0) begin
                    ccff_head_d = shreg_q[WORD_W-1];
                    shift_en_d  = 1'b1;
                    shreg_d     = shreg_q << 1;
                    rem_d       = rem_q - RC_W'(1);
                    bit_cnt_d   = bit_cnt_q + BC_W'(1);
                end
            end
            default: begin
                if (start && !abort) begin
                    state_d    = ST_LOAD;
                    shreg_d    = '0;
                    rem_d      = '0;
                    word_cnt_d = '0;
                    bit_cnt_d  = '0;
                    cfg_done_d = 1'b0;
                    error_d    = 1'b0;
                end
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge prog_clk) begin
        if (prog_reset) begin
            state_q     <= ST_IDLE;
            shreg_q     <= '0;
            rem_q       <= '0;
            word_cnt_q  <= '0;
            bit_cnt_q   <= '0;
            ccff_head_q <= 1'b0;
            shift_en_q  <= 1'b0;
            cfg_done_q  <= 1'b0;
            error_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            shreg_q     <= shreg_d;
            rem_q       <= rem_d;
            word_cnt_q  <= word_cnt_d;
            bit_cnt_q   <= bit_cnt_d;
            ccff_head_q <= ccff_head_d;
            shift_en_q  <= shift_en_d;
            cfg_done_q  <= cfg_done_d;
            error_q     <= error_d;
        end
    end

    assign ccff_head      = ccff_head_q;
    assign chain_shift_en = shift_en_q;
    assign cfg_done       = cfg_done_q;
    assign error          = error_q;
    assign busy           = (state_q == ST_LOAD);

endmodule

// File: tb/tb_ccff_chain_loader.sv
// Directed bench for ccff_chain_loader: expected chain bits are queued as
// words are accepted and compared against ccff_head on every shift cycle.
module tb_ccff_chain_loader;

    localparam int CHAIN_LEN = 66;
    localparam int WORD_W    = 8;
    localparam int NWORDS    = (CHAIN_LEN + WORD_W - 1) / WORD_W;
    localparam int LAST_BITS = CHAIN_LEN - (NWORDS - 1) * WORD_W;

    logic              prog_clk = 1'b0;
    logic              prog_reset;
    logic              start;
    logic              abort;
    logic [WORD_W-1:0] bs_data;
    logic              bs_valid;
    logic              bs_last;
    logic              bs_ready;
    logic              ccff_head;
    logic              chain_shift_en;
    logic              cfg_done;
    logic              busy;
    logic              error;

    ccff_chain_loader #(
        .CHAIN_LEN (CHAIN_LEN),
        .WORD_W    (WORD_W)
    ) dut (
        .prog_clk       (prog_clk),
        .prog_reset     (prog_reset),
        .start          (start),
        .abort          (abort),
        .bs_data        (bs_data),
        .bs_valid       (bs_valid),
        .bs_last        (bs_last),
        .bs_ready       (bs_ready),
        .ccff_head      (ccff_head),
        .chain_shift_en (chain_shift_en),
        .cfg_done       (cfg_done),
        .busy           (busy),
        .error          (error)
    );

    always #5 prog_clk = ~prog_clk;

    int checks   = 0;
    int failures = 0;

    logic [WORD_W-1:0] words [NWORDS];
    logic              lasts [NWORDS];
    int n_send, wi;
    int starve_at, starve_len, starve_cnt;
    int start_at, start_done;
    int cyc, shifts, first_sh, last_sh, err_cyc;
    logic head_ref;
    logic exp_q [$];

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chkn(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One clock; outputs sampled 1 time unit after the edge.
    task automatic tick();
        logic e;
        @(posedge prog_clk);
        #1;
        cyc++;
        if (chain_shift_en === 1'b1) begin
            shifts++;
            if (first_sh < 0) first_sh = cyc;
            last_sh = cyc;
            chk1("sb_has_entry", exp_q.size() != 0, 1'b1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk1("ccff_head", ccff_head, e);
            end
            head_ref = ccff_head;
        end else if (busy === 1'b1 && shifts > 0) begin
            chk1("head_hold", ccff_head, head_ref);
        end
    endtask

    // Present the next word (or starve), score it if it will be accepted, then clock.
    task automatic step();
        logic acc;
        logic err;
        int   nb;
        if (start_at >= 0 && start_done == 0 && shifts >= start_at) begin
            start      = 1'b1;
            start_done = 1;
        end
        if (wi < n_send) begin
            if (wi == starve_at && bs_ready === 1'b1 && starve_cnt < starve_len) begin
                bs_valid = 1'b0;
                starve_cnt++;
            end else begin
                bs_valid = 1'b1;
                bs_data  = words[wi];
                bs_last  = lasts[wi];
            end
        end else begin
            bs_valid = 1'b0;
        end
        acc = bs_valid && (bs_ready === 1'b1);
        if (acc) begin
            err = (lasts[wi] && wi < NWORDS - 1) || (!lasts[wi] && wi == NWORDS - 1);
            if (err) begin
                err_cyc = cyc + 1;
            end else begin
                nb = (wi == NWORDS - 1) ? LAST_BITS : WORD_W;
                for (int b = 0; b < nb; b++) exp_q.push_back(words[wi][WORD_W-1-b]);
            end
            wi++;
        end
        tick();
        start = 1'b0;
    endtask

    task automatic new_load(input string pfx, output int start_cyc);
        shifts     = 0;
        first_sh   = -1;
        last_sh    = -1;
        wi         = 0;
        starve_cnt = 0;
        start_done = 0;
        exp_q.delete();
        bs_valid = 1'b0;
        start    = 1'b1;
        tick();
        start = 1'b0;
        start_cyc = cyc;
        chk1({pfx, "_busy"},     busy,     1'b1);
        chk1({pfx, "_bs_ready"}, bs_ready, 1'b1);
        chk1({pfx, "_cfg_clr"},  cfg_done, 1'b0);
        chk1({pfx, "_err_clr"},  error,    1'b0);
    endtask

    task automatic run_to_end(input string pfx, input int budget, output int end_cyc);
        int n;
        n = 0;
        while (cfg_done !== 1'b1 && error !== 1'b1 && n < budget) begin
            step();
            n++;
        end
        chk1({pfx, "_finished"}, (cfg_done === 1'b1) || (error === 1'b1), 1'b1);
        end_cyc = cyc;
    endtask

    task automatic run_to_shifts(input string pfx, input int target, input int budget);
        int n;
        n = 0;
        while (shifts < target && n < budget) begin
            step();
            n++;
        end
        chkn({pfx, "_reached"}, shifts, target);
    endtask

    task automatic set_words(input logic rnd, input int last_idx);
        for (int i = 0; i < NWORDS; i++) begin
            words[i] = rnd ? WORD_W'($urandom) : ((i == NWORDS - 1) ? 8'hC0 : 8'hA5);
            lasts[i] = (i == last_idx);
        end
    endtask

    initial begin
        int sc;
        int ec;
        prog_reset = 1'b1;
        start      = 1'b0;
        abort      = 1'b0;
        bs_valid   = 1'b0;
        bs_last    = 1'b0;
        bs_data    = '0;
        starve_at  = -1;
        starve_len = 0;
        starve_cnt = 0;
        start_at   = -1;
        start_done = 0;
        n_send     = 0;
        wi         = 0;
        cyc        = 0;
        shifts     = 0;
        first_sh   = -1;
        last_sh    = -1;
        err_cyc    = -1;
        head_ref   = 1'b0;

        // Reset values
        tick();
        tick();
        chk1("rst_head",     ccff_head,      1'b0);
        chk1("rst_shift_en", chain_shift_en, 1'b0);
        chk1("rst_cfg_done", cfg_done,       1'b0);
        chk1("rst_busy",     busy,           1'b0);
        chk1("rst_error",    error,          1'b0);
        chk1("rst_bs_ready", bs_ready,       1'b0);
        prog_reset = 1'b0;

        // Words outside LOAD are ignored
        bs_valid = 1'b1;
        bs_data  = 8'hFF;
        bs_last  = 1'b1;
        tick();
        tick();
        chk1("idle_bs_ready", bs_ready,       1'b0);
        chk1("idle_shift_en", chain_shift_en, 1'b0);
        chk1("idle_busy",     busy,           1'b0);
        bs_valid = 1'b0;
        bs_last  = 1'b0;

        // start and abort together: abort wins
        start = 1'b1;
        abort = 1'b1;
        tick();
        start = 1'b0;
        abort = 1'b0;
        chk1("sa_busy",     busy,     1'b0);
        chk1("sa_bs_ready", bs_ready, 1'b0);
        tick();
        chk1("sa_busy_later", busy, 1'b0);

        // Nominal load: 8 x A5 then C0 with bs_last
        set_words(1'b0, NWORDS - 1);
        n_send = NWORDS;
        new_load("nom", sc);
        run_to_end("nom", 200, ec);
        chkn("nom_first_lat", first_sh - sc, 1);
        chkn("nom_shifts",    shifts, CHAIN_LEN);
        chkn("nom_span",      last_sh - first_sh + 1, CHAIN_LEN);
        chkn("nom_done_lat",  ec - last_sh, 1);
        chkn("nom_sb_left",   exp_q.size(), 0);
        chk1("nom_cfg_done",  cfg_done,       1'b1);
        chk1("nom_error",     error,          1'b0);
        chk1("nom_shift_en",  chain_shift_en, 1'b0);
        chk1("nom_busy",      busy,           1'b0);

        // abort in DONE has no effect
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk1("done_abort_cfg",  cfg_done, 1'b1);
        chk1("done_abort_busy", busy,     1'b0);

        // Starvation after word 3, plus a start pulse mid-load that must be ignored
        set_words(1'b1, NWORDS - 1);
        starve_at  = 4;
        starve_len = 5;
        start_at   = 30;
        new_load("stv", sc);
        run_to_end("stv", 200, ec);
        chkn("stv_shifts",   shifts, CHAIN_LEN);
        chkn("stv_gap",      (last_sh - first_sh + 1) - shifts, 5);
        chkn("stv_done_lat", ec - last_sh, 1);
        chkn("stv_sb_left",  exp_q.size(), 0);
        chk1("stv_cfg_done", cfg_done, 1'b1);
        starve_at = -1;
        start_at  = -1;

        // Early bs_last on word index 4
        set_words(1'b1, 4);
        n_send = 5;
        new_load("el", sc);
        run_to_end("el", 200, ec);
        chk1("el_error",     error, 1'b1);
        chkn("el_err_lat",   ec, err_cyc);
        chkn("el_shifts",    shifts, 32);
        chk1("el_cfg_done",  cfg_done,       1'b0);
        chk1("el_bs_ready",  bs_ready,       1'b0);
        chk1("el_shift_en",  chain_shift_en, 1'b0);
        chk1("el_busy",      busy,           1'b0);
        bs_valid = 1'b1;
        tick();
        tick();
        chk1("el_ready_later", bs_ready, 1'b0);
        chkn("el_shifts_later", shifts, 32);
        chk1("el_error_held",   error, 1'b1);
        bs_valid = 1'b0;

        // Missing bs_last on the final word, then recovery
        set_words(1'b1, -1);
        n_send = NWORDS;
        new_load("ml", sc);
        run_to_end("ml", 200, ec);
        chk1("ml_error",    error, 1'b1);
        chkn("ml_shifts",   shifts, 64);
        chk1("ml_cfg_done", cfg_done, 1'b0);
        set_words(1'b1, NWORDS - 1);
        new_load("rec", sc);
        run_to_end("rec", 200, ec);
        chkn("rec_shifts",  shifts, CHAIN_LEN);
        chkn("rec_sb_left", exp_q.size(), 0);
        chk1("rec_cfg_done", cfg_done, 1'b1);
        chk1("rec_error",    error,    1'b0);

        // Abort after 20 shifts
        new_load("ab", sc);
        run_to_shifts("ab", 20, 100);
        bs_valid = 1'b0;
        abort    = 1'b1;
        tick();
        abort = 1'b0;
        exp_q.delete();
        chk1("ab_shift_en", chain_shift_en, 1'b0);
        chk1("ab_busy",     busy,           1'b0);
        chk1("ab_cfg_done", cfg_done,       1'b0);
        chk1("ab_error",    error,          1'b0);
        chk1("ab_bs_ready", bs_ready,       1'b0);
        chkn("ab_shifts",   shifts, 20);

        // Reset after 20 shifts
        new_load("rs", sc);
        run_to_shifts("rs", 20, 100);
        bs_valid   = 1'b0;
        prog_reset = 1'b1;
        tick();
        exp_q.delete();
        chk1("rs_shift_en", chain_shift_en, 1'b0);
        chk1("rs_busy",     busy,           1'b0);
        chk1("rs_cfg_done", cfg_done,       1'b0);
        chk1("rs_head",     ccff_head,      1'b0);
        chk1("rs_error",    error,          1'b0);
        prog_reset = 1'b0;
        tick();
        chk1("rs_idle_busy", busy, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
